sdlc_rx: RTL and testbench

- Econet receive deframer. Samples the network clock and receive data lines in the mclk domain.
- Performs HDLC flag/abort detection, zero-bit deletion and byte assembly.
- Checks CRC-16 and strips it before delivery. Drives the line-status outputs.
- Sits directly downstream of the rxdata/netclk pins. Feeds the host-side receive FIFO and the irq logic in the bridge top level.

---
 rtl/sdlc_rx.sv | 247 ++++++++++++++++++++++++
 tb/tb_sdlc_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdlc_rx.sv
// rtl/sdlc_rx.sv - Econet HDLC receive deframer with CRC-16 check
module sdlc_rx #(
  parameter int NOCLK_CYCLES = 4096,
  parameter int IDLE_ONES    = 15
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       netclk,
  input  logic       rxdata,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_crc_ok,
  output logic       rx_err,
  output logic       rx_abort,
  output logic       idle,
  output logic       no_clock
);

  localparam int              NCW       = $clog2(NOCLK_CYCLES + 1);
  localparam logic [NCW-1:0]  NOCLK_MAX = NCW'(NOCLK_CYCLES);
  localparam logic [NCW-1:0]  NOCLK_ONE = NCW'(1);
  localparam logic [3:0]      IDLE_MAX  = 4'(IDLE_ONES);
  localparam logic [15:0]     CRC_INIT  = 16'hFFFF;
  localparam logic [15:0]     CRC_GOOD  = 16'hF0B8;

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;

  // Reflected CRC-16 (0x8408) over one byte, LSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Line synchronizers and clock-loss counter
  logic           nclk_s1_q, nclk_s2_q, nclk_s3_q;
  logic           rxd_s1_q, rxd_s2_q;
  logic [NCW-1:0] ncnt_q;
  logic           noclk_prev_q;

  logic strobe, bit_v, noclk_now, noclk_rise;
  logic ev_flag, ev_abort, ev_data;

  assign strobe     = nclk_s2_q & ~nclk_s3_q;
  assign bit_v      = rxd_s2_q;
  assign noclk_now  = (ncnt_q == NOCLK_MAX);
  assign noclk_rise = noclk_now & ~noclk_prev_q;

  // Registered receive state
  state_t      state_q, state_d;
  logic [3:0]  ones_q, ones_d;
  logic        idle_q, idle_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  pipe0_q, pipe0_d, pipe1_q, pipe1_d;
  logic [1:0]  pipe_cnt_q, pipe_cnt_d;
  logic        first_q, first_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_sof_q, rx_sof_d;
  logic        rx_eof_q, rx_eof_d;
  logic        rx_crc_ok_q, rx_crc_ok_d;
  logic        rx_err_q, rx_err_d;
  logic        rx_abort_q, rx_abort_d;
  logic [7:0]  byte_w;

  // A one after six ones is an abort; a zero after five is stuffing, after six a flag
  assign ev_flag  = strobe & ~bit_v & (ones_q == 4'd6);
  assign ev_abort = strobe &  bit_v & (ones_q == 4'd6);
  assign ev_data  = strobe & (bit_v | ((ones_q != 4'd5) && (ones_q != 4'd6)));

  // Synchronize netclk/rxdata and time the gap between netclk edges
  always_ff @(posedge mclk) begin
    if (reset) begin
      nclk_s1_q    <= 1'b0;
      nclk_s2_q    <= 1'b0;
      nclk_s3_q    <= 1'b0;
      rxd_s1_q     <= 1'b0;
      rxd_s2_q     <= 1'b0;
      ncnt_q       <= '0;
      noclk_prev_q <= 1'b0;
    end else begin
      nclk_s1_q    <= netclk;
      nclk_s2_q    <= nclk_s1_q;
      nclk_s3_q    <= nclk_s2_q;
      rxd_s1_q     <= rxdata;
      rxd_s2_q     <= rxd_s1_q;
      noclk_prev_q <= noclk_now;
      if (strobe)          ncnt_q <= '0;
      else if (!noclk_now) ncnt_q <= ncnt_q + NOCLK_ONE;
    end
  end

  // Deframer next state: bit classification, byte assembly, holdoff pipe, frame close
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    idle_d      = idle_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    pipe0_d     = pipe0_q;
    pipe1_d     = pipe1_q;
    pipe_cnt_d  = pipe_cnt_q;
    first_d     = first_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sof_d    = 1'b0;
    rx_eof_d    = 1'b0;
    rx_crc_ok_d = 1'b0;
    rx_err_d    = 1'b0;
    rx_abort_d  = 1'b0;
    byte_w      = {bit_v, shift_q[7:1]};

    if (strobe) begin
      if (bit_v) begin
        ones_d = (ones_q == 4'hF) ? 4'hF : ones_q + 4'd1;
        if (ones_d == IDLE_MAX) idle_d = 1'b1;
      end else begin
        ones_d = 4'd0;
        idle_d = 1'b0;
      end
    end

    case (state_q)
      HUNT: begin
        if (ev_flag) state_d = SYNC;
      end
      SYNC: begin
        if (ev_data) begin
          state_d    = DATA;
          shift_d    = byte_w;
          bit_cnt_d  = 3'd1;
          byte_cnt_d = 2'd0;
          crc_d      = CRC_INIT;
          pipe_cnt_d = 2'd0;
          first_d    = 1'b1;
        end
      end
      DATA: begin
        if (noclk_rise || ev_abort) begin
          rx_abort_d = 1'b1;
          pipe_cnt_d = 2'd0;
          state_d    = HUNT;
        end else if (ev_flag) begin
          // Closing flag leaves its leading 0 and six 1s as seven stray bits
          pipe_cnt_d = 2'd0;
          state_d    = SYNC;
          if (bit_cnt_q == 3'd7 && byte_cnt_q == 2'd3) begin
            rx_eof_d    = 1'b1;
            rx_crc_ok_d = (crc_q == CRC_GOOD);
          end else begin
            rx_err_d = 1'b1;
          end
        end else if (ev_data) begin
          shift_d = byte_w;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            crc_d      = crc_byte(crc_q, byte_w);
            byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
            // Two-deep holdoff keeps the FCS bytes from ever being delivered
            if (pipe_cnt_q == 2'd2) begin
              rx_data_d  = pipe0_q;
              rx_valid_d = 1'b1;
              rx_sof_d   = first_q;
              first_d    = 1'b0;
              pipe0_d    = pipe1_q;
              pipe1_d    = byte_w;
            end else if (pipe_cnt_q == 2'd1) begin
              pipe1_d    = byte_w;
              pipe_cnt_d = 2'd2;
            end else begin
              pipe0_d    = byte_w;
              pipe_cnt_d = 2'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Deframer state register
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= HUNT;
      ones_q      <= 4'd0;
      idle_q      <= 1'b0;
      shift_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      crc_q       <= CRC_INIT;
      pipe0_q     <= 8'd0;
      pipe1_q     <= 8'd0;
      pipe_cnt_q  <= 2'd0;
      first_q     <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_crc_ok_q <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_abort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      idle_q      <= idle_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      pipe0_q     <= pipe0_d;
      pipe1_q     <= pipe1_d;
      pipe_cnt_q  <= pipe_cnt_d;
      first_q     <= first_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sof_q    <= rx_sof_d;
      rx_eof_q    <= rx_eof_d;
      rx_crc_ok_q <= rx_crc_ok_d;
      rx_err_q    <= rx_err_d;
      rx_abort_q  <= rx_abort_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sof    = rx_sof_q;
  assign rx_eof    = rx_eof_q;
  assign rx_crc_ok = rx_crc_ok_q;
  assign rx_err    = rx_err_q;
  assign rx_abort  = rx_abort_q;
  assign idle      = idle_q;
  assign no_clock  = noclk_now;

endmodule

// File: tb/tb_sdlc_rx.sv
// tb/tb_sdlc_rx.sv - scoreboard bench for sdlc_rx
module tb_sdlc_rx;

  logic       mclk = 1'b0;
  logic       reset, netclk, rxdata;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_abort, idle, no_clock;

  sdlc_rx dut (
    .mclk(mclk), .reset(reset), .netclk(netclk), .rxdata(rxdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .rx_abort(rx_abort),
    .idle(idle), .no_clock(no_clock)
  );

  always #5 mclk = ~mclk;

  localparam int K_VALID = 0, K_EOF = 1, K_ERR = 2, K_ABORT = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       sof;
    logic       crc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  tx_ones = 0;
  logic [7:0] fb [0:15];
  int  fn;

  task automatic push(input int k, input logic [7:0] d, input logic s, input logic c);
    ev_t e;
    e.kind = k; e.data = d; e.sof = s; e.crc = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic mon_pop(input int k, input logic [7:0] d, input logic s, input logic c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d data 0x%0h sof %0d crc %0d, expected none", k, d, s, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && (k != K_VALID || (e.data == d && e.sof == s)) && (k != K_EOF || e.crc == c))
        passes++;
      else
        $display("FAIL event: got kind %0d data 0x%0h sof %0d crc %0d, expected kind %0d data 0x%0h sof %0d crc %0d",
                 k, d, s, c, e.kind, e.data, e.sof, e.crc);
    end
  endtask

  // Monitor: every output strobe is matched against the head of the expectation queue
  always @(negedge mclk) begin
    if (!reset) begin
      if (rx_valid) mon_pop(K_VALID, rx_data, rx_sof, 1'b0);
      else if (rx_sof) chk("sof_without_valid", 32'(rx_sof), 32'd0);
      if (rx_valid && rx_eof) chk("valid_with_eof", 32'd1, 32'd0);
      if (rx_eof)   mon_pop(K_EOF, 8'd0, 1'b0, rx_crc_ok);
      if (rx_err)   mon_pop(K_ERR, 8'd0, 1'b0, 1'b0);
      if (rx_abort) mon_pop(K_ABORT, 8'd0, 1'b0, 1'b0);
    end
  end

  task automatic send_bit(input logic b);
    netclk = 1'b0;
    rxdata = b;
    repeat (4) @(negedge mclk);
    netclk = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
    tx_ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (b[i]) begin
        tx_ones++;
        if (tx_ones == 5) begin
          send_bit(1'b0);
          tx_ones = 0;
        end
      end else begin
        tx_ones = 0;
      end
    end
  endtask

  task automatic send_fb();
    for (int i = 0; i < fn; i++) send_byte(fb[i]);
  endtask

  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ fb[i][j]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic add_fcs();
    logic [15:0] c;
    c = ~model_crc(fn);
    fb[fn]   = c[7:0];
    fb[fn+1] = c[15:8];
    fn += 2;
  endtask

  task automatic expect_payload(input logic crc_ok);
    for (int i = 0; i < fn - 2; i++) push(K_VALID, fb[i], i == 0, 1'b0);
    push(K_EOF, 8'd0, 1'b0, crc_ok);
  endtask

  task automatic load_123(input logic [7:0] fcs_lo);
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    fb[9]  = fcs_lo;
    fb[10] = 8'h90;
    fn     = 11;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rx_data"},   32'(rx_data),   32'd0);
    chk({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    chk({tag, "_rx_sof"},    32'(rx_sof),    32'd0);
    chk({tag, "_rx_eof"},    32'(rx_eof),    32'd0);
    chk({tag, "_rx_crc_ok"}, 32'(rx_crc_ok), 32'd0);
    chk({tag, "_rx_err"},    32'(rx_err),    32'd0);
    chk({tag, "_rx_abort"},  32'(rx_abort),  32'd0);
    chk({tag, "_idle"},      32'(idle),      32'd0);
    chk({tag, "_no_clock"},  32'(no_clock),  32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    netclk = 1'b0;
    rxdata = 1'b1;
    repeat (3) @(negedge mclk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Good "123456789" frame, FCS 6E 90
    repeat (3) send_bit(1'b1);
    send_flag();
    load_123(8'h6E);
    expect_payload(1'b1);
    send_fb();
    send_flag();

    // Same frame, corrupted FCS; opened by the shared closing flag
    load_123(8'h6F);
    expect_payload(1'b0);
    send_fb();
    send_flag();

    // Payload needing zero stuffing
    fb[0] = 8'h7E; fb[1] = 8'hFF; fn = 2;
    add_fcs();
    expect_payload(1'b1);
    send_fb();
    send_flag();

    // Three bytes plus three stray bits: non-octet close
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fn = 3;
    push(K_VALID, 8'h01, 1'b1, 1'b0);
    push(K_VALID, 8'h02, 1'b0, 1'b0);
    push(K_ERR, 8'd0, 1'b0, 1'b0);
    send_fb();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_flag();

    // Back-to-back frames sharing one flag
    fb[0] = 8'hA5; fb[1] = 8'h5A; fn = 2;
    add_fcs();
    expect_payload(1'b1);
    send_fb();
    send_flag();
    fb[0] = 8'h12; fb[1] = 8'h34; fn = 2;
    add_fcs();
    expect_payload(1'b1);
    send_fb();
    send_flag();

    // Abort after 0x55, then run the line to idle
    push(K_ABORT, 8'd0, 1'b0, 1'b0);
    send_byte(8'h55);
    repeat (14) send_bit(1'b1);
    chk("idle_after_14_ones", 32'(idle), 32'd0);
    send_bit(1'b1);
    chk("idle_after_15_ones", 32'(idle), 32'd1);
    send_bit(1'b0);
    chk("idle_cleared_by_zero", 32'(idle), 32'd0);

    // Clock loss mid-frame
    send_flag();
    send_byte(8'h31);
    send_byte(8'h32);
    chk("no_clock_running", 32'(no_clock), 32'd0);
    push(K_ABORT, 8'd0, 1'b0, 1'b0);
    netclk = 1'b0;
    rxdata = 1'b1;
    repeat (4200) @(negedge mclk);
    chk("no_clock_stopped", 32'(no_clock), 32'd1);
    netclk = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    chk("no_clock_at_strobe", 32'(no_clock), 32'd1);
    @(negedge mclk);
    chk("no_clock_after_strobe", 32'(no_clock), 32'd0);
    repeat (2) @(negedge mclk);

    // Reset in the middle of a frame, then a clean frame
    repeat (3) send_bit(1'b1);
    send_flag();
    send_byte(8'h31);
    send_byte(8'h32);
    netclk = 1'b0;
    repeat (4) @(negedge mclk);
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    check_outputs_zero("midreset");
    reset = 1'b0;
    repeat (3) send_bit(1'b1);
    send_flag();
    load_123(8'h6E);
    expect_payload(1'b1);
    send_fb();
    send_flag();

    repeat (20) @(negedge mclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
